dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

- Shares the single-port 256x8 data RAM between the CPU and one host requester, for example a board loader or display engine.
- The CPU always wins any cycle in which it executes a load or store. Host commands are queued and issued in order during free cycles.
- Read data returns to the host through a registered response port.
- Sits between the CPU data-memory pins and the RAM. The RAM has asynchronous read and synchronous write.

## Interface
Parameters:
- DEPTH, 4: host command queue depth; must be a power of 2, range 2..16.
- STARVE_LIMIT, 16: number of cycles a queued head command may wait before the starvation flag sets.

Ports:
- CLK  in  1  system clock; the only clock.
- RESET  in  1  synchronous, active-high reset.
- cpu_op  in  4  CPU opcode, Iin[15:12].
- cpu_addr  in  8  CPU data address.
- cpu_wdata  in  8  CPU store data.
- cpu_we  in  1  CPU write strobe (MW).
- cpu_rdata  out  8  load data to the CPU; equals mem_rdata combinationally.
- host_valid  in  1  host command valid.
- host_ready  out  1  queue can accept a command.
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  8  host address.
- host_wdata  in  8  host write data.
- rsp_valid  out  1  one-cycle pulse; rsp_data is valid.
- rsp_data  out  8  host read data.
- starve  out  1  sticky starvation flag.
- mem_addr  out  8  RAM address.
- mem_wdata  out  8  RAM write data.
- mem_we  out  1  RAM write enable.
- mem_rdata  in  8  RAM read data (asynchronous).

## Operation
CPU slot:
- cpu_slot = !RESET && (cpu_op == 4'b0010 || cpu_op == 4'b0100).
- While cpu_slot is high: mem_addr = cpu_addr, mem_wdata = cpu_wdata, mem_we = cpu_we. No host command issues.
- The CPU is never stalled.

Host queue:
- FIFO of {we, addr, wdata}, DEPTH entries.
- host_ready = (count < DEPTH). The ready calculation does not credit a same-cycle pop.
- A command is accepted when host_valid && host_ready.

Issue:
- A host command issues when !cpu_slot && count != 0.
- During issue: mem_addr = head.addr, mem_wdata = head.wdata, mem_we = head.we.
- The head pops at the end of the issue cycle.
- If the command is a read, rsp_data <= mem_rdata and rsp_valid <= 1 on that clock edge.

Idle cycle (no CPU slot, queue empty):
- mem_addr = cpu_addr, mem_we = 0.

Responses:
- Commands complete strictly in order.
- Writes produce no response.
- A read issued after a queued write to the same address returns the new data.
- Host reads observe CPU stores completed in earlier cycles.

Counters:
- Read and write pointers are log2(DEPTH) bits wide and wrap modulo DEPTH.
- count is log2(DEPTH)+1 bits wide.
- Simultaneous push and pop leaves count unchanged.

Reset values:
- Queue empty (count = 0).
- rsp_valid = 0, rsp_data = 8'h00, starve = 0, wait counter = 0.
- host_ready reads 1 from the first cycle after reset.

Reset mid-operation:
- All queued commands are discarded with no response.
- A command presented in the reset cycle is not accepted.
- During RESET, cpu_slot = 0 and mem_we = 0.

## Timing
- Minimum latency: read accepted at edge N issues in cycle N+1; rsp_valid is high in cycle N+2.
- Each cycle of cpu_slot delays issue by one cycle.
- At most one host command issues per cycle; sustained throughput is 1 command per free cycle.
- A write is visible in the RAM at the end of its issue cycle.
- rsp_valid is never high in two cycles unless two reads issued in consecutive cycles.
- The host must accept responses every cycle; there is no rsp_ready.

## Configuration
- DMEM_ARB_STARVE_EN defined:
  - A wait counter increments each cycle the queue is non-empty and no issue occurs.
  - It clears on every issue and whenever the queue is empty.
  - When the counter reaches STARVE_LIMIT, starve sets and stays set until RESET.
- DMEM_ARB_STARVE_EN undefined:
  - The counter is not built.
  - starve is tied to 0.

## Test plan
- Host write addr 8'h10 = 8'hA5, then read 8'h10, with cpu_op = 4'b0001 throughout -> write issues at cycle 1, read at cycle 2; rsp_valid in cycle 3 with rsp_data = 8'hA5.
- Host read queued while cpu_op = 4'b0100 (store 8'h3C to 8'h20) for 3 cycles, with the host reading 8'h20 -> no host issue during the 3 cycles; mem_we follows cpu_we; rsp_data = 8'h3C after the CPU slots end.
- Push 5 commands back-to-back with DEPTH = 4 and cpu_op = 4'b0010 held -> host_ready drops after the 4th accept; the 5th is held until a pop; all responses arrive in order.
- Pulse RESET with 3 commands queued -> count = 0, no rsp_valid afterwards, host_ready = 1 in the next cycle.
- With DMEM_ARB_STARVE_EN defined, hold cpu_op = 4'b0010 for 16 cycles with 1 command queued -> starve = 1 on the 16th cycle and stays 1 after the queue drains; with the macro undefined, starve stays 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Data-RAM arbiter: CPU loads/stores always win, host commands queue and issue in free cycles.
// Optional starvation detector enabled by defining DMEM_ARB_STARVE_EN.
module dmem_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 16
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] cpu_op,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    input  logic       cpu_we,
    output logic [7:0] cpu_rdata,
    input  logic       host_valid,
    output logic       host_ready,
    input  logic       host_we,
    input  logic [7:0] host_addr,
    input  logic [7:0] host_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       starve,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       mem_we,
    input  logic [7:0] mem_rdata
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic          r_q_we    [DEPTH];
    logic [7:0]    r_q_addr  [DEPTH];
    logic [7:0]    r_q_wdata [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          r_rsp_valid;
    logic [7:0]    r_rsp_data;

    logic          w_cpu_slot;
    logic          w_nonempty;
    logic          w_issue;
    logic          w_push;
    logic          w_head_we;
    logic [7:0]    w_head_addr;
    logic [7:0]    w_head_wdata;

    assign w_cpu_slot   = !RESET && (cpu_op == 4'b0010 || cpu_op == 4'b0100);
    assign w_nonempty   = (r_count != '0);
    assign w_issue      = !RESET && !w_cpu_slot && w_nonempty;
    assign host_ready   = (r_count < DEPTH_C);
    assign w_push       = host_valid && host_ready;
    assign w_head_we    = r_q_we[r_rptr];
    assign w_head_addr  = r_q_addr[r_rptr];
    assign w_head_wdata = r_q_wdata[r_rptr];

    assign cpu_rdata = mem_rdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;

    // Command storage; entries need no reset since count gates their use.
    always_ff @(posedge CLK) begin
        if (!RESET && w_push) begin
            r_q_we[r_wptr]    <= host_we;
            r_q_addr[r_wptr]  <= host_addr;
            r_q_wdata[r_wptr] <= host_wdata;
        end
    end

    // Queue pointers and occupancy; reset discards anything queued.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_issue) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_issue) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_issue) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // RAM port steering: CPU slot first, then queue head, else idle.
    always_comb begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = 1'b0;
        if (w_cpu_slot) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_we    = cpu_we;
        end else if (w_issue) begin
            mem_addr  = w_head_addr;
            mem_wdata = w_head_wdata;
            mem_we    = w_head_we;
        end
    end

    // Registered read response captured from the asynchronous RAM.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 8'h00;
        end else begin
            r_rsp_valid <= w_issue && !w_head_we;
            if (w_issue && !w_head_we) begin
                r_rsp_data <= mem_rdata;
            end
        end
    end

`ifdef DMEM_ARB_STARVE_EN
    localparam int WW = $clog2(STARVE_LIMIT + 1);
    localparam logic [WW-1:0] LIMIT_C = WW'(STARVE_LIMIT);

    logic [WW-1:0] r_wait;
    logic          r_starve;
    logic [WW-1:0] w_wait_nxt;

    // Wait count saturates at the limit so it can never wrap back.
    always_comb begin
        w_wait_nxt = r_wait;
        if (w_issue || !w_nonempty) begin
            w_wait_nxt = '0;
        end else if (r_wait != LIMIT_C) begin
            w_wait_nxt = r_wait + 1'b1;
        end
    end

    // Sticky flag set once the head has waited the full limit.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_wait   <= '0;
            r_starve <= 1'b0;
        end else begin
            r_wait <= w_wait_nxt;
            if (w_wait_nxt == LIMIT_C) begin
                r_starve <= 1'b1;
            end
        end
    end

    assign starve = r_starve;
`else
    assign starve = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed scenarios then random traffic,
// checked against a transaction-level queue/memory model.
module tb_dmem_arbiter;

    localparam int DEPTH = 4;
    localparam int LIMIT = 16;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [3:0] cpu_op;
    logic [7:0] cpu_addr;
    logic [7:0] cpu_wdata;
    logic       cpu_we;
    logic [7:0] cpu_rdata;
    logic       host_valid;
    logic       host_ready;
    logic       host_we;
    logic [7:0] host_addr;
    logic [7:0] host_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       starve;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic [7:0] mem_rdata;

    dmem_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .CLK(CLK), .RESET(RESET),
        .cpu_op(cpu_op), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_we(cpu_we), .cpu_rdata(cpu_rdata),
        .host_valid(host_valid), .host_ready(host_ready),
        .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .starve(starve),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata)
    );

    always #5 CLK = ~CLK;

    // Environment RAM: asynchronous read, synchronous write.
    logic [7:0] ram [256];
    assign mem_rdata = ram[mem_addr];
    always @(posedge CLK) if (mem_we) ram[mem_addr] <= mem_wdata;

    typedef struct {logic we; logic [7:0] a; logic [7:0] d;} cmd_t;
    typedef struct {logic [7:0] d; int cyc;} rsp_t;

    cmd_t       mq[$];
    rsp_t       sb[$];
    logic [7:0] gold [256];
    int         mwait = 0;
    bit         mstarve = 0;
    int         dcyc = 0;
    int         mcyc = 0;
    int         n_cmp = 0;
    int         n_mis = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, dcyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever a response is presented.
    always @(negedge CLK) begin
        rsp_t e;
        mcyc++;
        if (sb.size() != 0 && sb[0].cyc < mcyc) begin
            e = sb.pop_front();
            n_cmp++;
            n_mis++;
            $display("FAIL rsp_missing: got none expected %0h at cycle %0d", e.d, e.cyc);
        end
        if (rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_mis++;
                $display("FAIL rsp_spurious: got %0h expected no response (cycle %0d)", rsp_data, mcyc);
            end else begin
                e = sb.pop_front();
                check("rsp_data", {24'h0, rsp_data}, {24'h0, e.d});
                check("rsp_cycle", mcyc, e.cyc);
            end
        end
    end

    // One clock cycle: drive inputs, check combinational outputs, advance the model.
    task automatic step(input bit rst, input logic [3:0] op, input logic [7:0] ca,
                        input logic [7:0] cd, input logic cwe, input logic hv,
                        input logic hwe, input logic [7:0] ha, input logic [7:0] hd,
                        output bit acc);
        bit   slot, iss, ewe;
        cmd_t h;
        int   sz;
        @(negedge CLK);
        dcyc++;
        RESET = rst; cpu_op = op; cpu_addr = ca; cpu_wdata = cd; cpu_we = cwe;
        host_valid = hv; host_we = hwe; host_addr = ha; host_wdata = hd;
        #1;
        sz   = mq.size();
        slot = !rst && (op == 4'b0010 || op == 4'b0100);
        iss  = !rst && !slot && sz != 0;
        h    = '{1'b0, 8'h00, 8'h00};
        if (iss) h = mq[0];
        ewe = slot ? cwe : (iss ? h.we : 1'b0);
        check("mem_we", {31'h0, mem_we}, {31'h0, ewe});
        check("mem_addr", {24'h0, mem_addr}, {24'h0, (iss ? h.a : ca)});
        if (ewe) check("mem_wdata", {24'h0, mem_wdata}, {24'h0, (iss ? h.d : cd)});
        if (slot && !cwe) check("cpu_rdata", {24'h0, cpu_rdata}, {24'h0, gold[ca]});
        if (!rst) begin
            check("host_ready", {31'h0, host_ready}, {31'h0, (sz < DEPTH)});
            check("starve", {31'h0, starve}, {31'h0, mstarve});
        end
        acc = 1'b0;
        if (rst) begin
            mq.delete();
            mwait   = 0;
            mstarve = 0;
        end else begin
            if (slot && cwe) gold[ca] = cd;
            if (iss) begin
                h = mq.pop_front();
                if (h.we) gold[h.a] = h.d;
                else sb.push_back('{gold[h.a], dcyc + 1});
            end
            acc = hv && (sz < DEPTH);
            if (acc) mq.push_back('{hwe, ha, hd});
`ifdef DMEM_ARB_STARVE_EN
            if (iss || sz == 0) mwait = 0;
            else if (mwait < LIMIT) mwait++;
            if (mwait == LIMIT) mstarve = 1;
`endif
        end
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(0, 4'h1, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, a);
    endtask

    initial begin
        bit   a;
        int   k;
        int   guard;
        logic [3:0] op;
        logic [7:0] v;
        for (int i = 0; i < 256; i++) begin
            v = 8'($urandom);
            ram[i]  = v;
            gold[i] = v;
        end
        RESET = 1; cpu_op = 0; cpu_addr = 0; cpu_wdata = 0; cpu_we = 0;
        host_valid = 0; host_we = 0; host_addr = 0; host_wdata = 0;

        step(1, 4'h1, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, a);
        step(1, 4'h1, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, a);
        check("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("reset_rsp_data", {24'h0, rsp_data}, 32'h0);

        // Write then read back with no CPU traffic.
        step(0, 4'h1, 8'h00, 8'h00, 0, 1, 1, 8'h10, 8'hA5, a);
        step(0, 4'h1, 8'h00, 8'h00, 0, 1, 0, 8'h10, 8'h00, a);
        idle(3);

        // Host read held off by three CPU stores to the same address.
        step(0, 4'h4, 8'h20, 8'h3C, 1, 1, 0, 8'h20, 8'h00, a);
        step(0, 4'h4, 8'h20, 8'h3C, 1, 0, 0, 8'h00, 8'h00, a);
        step(0, 4'h4, 8'h21, 8'h77, 1, 0, 0, 8'h00, 8'h00, a);
        idle(3);

        // Five commands against a depth-4 queue while CPU loads hold the port.
        k = 0;
        for (int i = 0; i < 8; i++) begin
            step(0, 4'h2, 8'h10, 8'h00, 0, (k < 5), (k == 2), 8'h40 + 8'(k), 8'hC0 + 8'(k), a);
            if (a) k++;
        end
        check("full_accepts", k, 4);
        guard = 0;
        while (k < 5 && guard < 20) begin
            step(0, 4'h1, 8'h00, 8'h00, 0, 1, 0, 8'h44, 8'h00, a);
            if (a) k++;
            guard++;
        end
        check("fifth_accepted", k, 5);
        idle(8);

        // Reset with three commands queued.
        for (int i = 0; i < 3; i++)
            step(0, 4'h2, 8'h00, 8'h00, 0, 1, 0, 8'h50 + 8'(i), 8'h00, a);
        step(1, 4'h2, 8'h00, 8'h00, 1, 1, 0, 8'h60, 8'h00, a);
        step(0, 4'h1, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, a);
        check("post_reset_ready", {31'h0, host_ready}, 32'h1);
        idle(4);

        // Head held off by CPU loads for longer than the starvation limit.
        step(0, 4'h2, 8'h00, 8'h00, 0, 1, 0, 8'h10, 8'h00, a);
        for (int i = 0; i < LIMIT + 2; i++)
            step(0, 4'h2, 8'h01, 8'h00, 0, 0, 0, 8'h00, 8'h00, a);
        idle(4);
`ifdef DMEM_ARB_STARVE_EN
        check("starve_sticky", {31'h0, starve}, 32'h1);
`else
        check("starve_tied", {31'h0, starve}, 32'h0);
`endif
        step(1, 4'h1, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, a);

        // Randomised traffic over a small address window to force collisions.
        for (int i = 0; i < 2000; i++) begin
            k  = $urandom_range(0, 9);
            op = (k < 3) ? 4'h2 : (k < 5) ? 4'h4 : 4'($urandom_range(0, 15));
            step(($urandom_range(0, 249) == 0), op, 8'($urandom_range(0, 15)), 8'($urandom),
                 (op == 4'h4) ? 1'b1 : 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom), a);
        end

        guard = 0;
        while ((mq.size() != 0 || sb.size() != 0) && guard < 50) begin
            idle(1);
            guard++;
        end
        idle(2);
        check("drain_queue", mq.size(), 0);
        check("drain_scoreboard", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
